mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one main-memory block port between the instruction-cache refill path and the data-cache refill/write-back path. Sits below both caches: each cache sees a private memory-like port with the usual read/write/busywait handshake, and the arbiter serialises their block transfers onto the single memory. One transaction is in flight at a time; the data cache has priority unless round-robin is compiled in.

## Interface
- ADDR_W, 28, block address width (word address minus block offset)
- BLOCK_W, 128, block data width in bits
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- icache_mem_read  in  1  I-cache block read request, held until its busywait drops
- icache_mem_address  in  ADDR_W  I-cache block address
- icache_mem_readdata  out  BLOCK_W  block returned to I-cache
- icache_mem_busywait  out  1  stall to I-cache
- dcache_mem_read  in  1  D-cache block read request
- dcache_mem_write  in  1  D-cache block write request (read and write never both high)
- dcache_mem_address  in  ADDR_W  D-cache block address
- dcache_mem_writedata  in  BLOCK_W  D-cache write-back block
- dcache_mem_readdata  out  BLOCK_W  block returned to D-cache
- dcache_mem_busywait  out  1  stall to D-cache
- mem_read, mem_write  out  1  memory command, level, held for whole transaction
- mem_address  out  ADDR_W  memory block address
- mem_writedata  out  BLOCK_W  memory write data
- mem_readdata  in  BLOCK_W  memory read data, valid in completion cycle
- mem_busywait  in  1  memory stall

## Operation
- States: IDLE, GRANT_I, GRANT_D. Registers: state, issued (1 b), last_grant (1 b, round-robin only).
- IDLE: no memory command. If dcache req (read|write) pending -> GRANT_D; else if icache_mem_read -> GRANT_I. Both pending: GRANT_D (fixed priority).
- GRANT_x: mem_read/mem_write/mem_address/mem_writedata driven from granted requester's live inputs; other requester's fields ignored.
- issued: cleared on grant entry, set at first edge in GRANT_x. Completion = GRANT_x && issued && !mem_busywait. Masks the cycle before the memory raises busywait.
- On completion edge: state -> IDLE, issued -> 0. No back-to-back grants; exactly one IDLE cycle between transactions.
- icache_mem_busywait = icache_mem_read && !(GRANT_I completion). Same for D-cache with (read|write). A requester waiting in IDLE or while the other is granted sees busywait = 1.
- icache_mem_readdata and dcache_mem_readdata = mem_readdata (pass-through, both always). Validity is defined only by busywait low.
- Requester dropping its request mid-grant is illegal. Behaviour is undefined, but the FSM must still return to IDLE on the next completion.

## Timing
- Reset (RESET=0, asynchronous): state=IDLE, issued=0, last_grant=I. mem_read=mem_write=0. mem_address and mem_writedata=0. Both busywaits forced 0 while RESET=0.
- Reset mid-transaction: command drops immediately; memory is expected to be reset by the same signal.
- Request at edge k (sampled in IDLE) -> grant state from k+1. Memory command visible in cycle k+1. issued=1 from k+2.
- Minimum latency request-to-busywait-low: 2 cycles plus memory busywait duration.
- Memory holds busywait N cycles after command -> completion in cycle k+1+N (N≥1). Requester's busywait low in that cycle; its next-edge sample sees data.
- Memory commands and grant are registered from state. Busywaits are combinational from state, issued, mem_busywait and requests.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: when both pending in IDLE, grant the requester not in last_grant. last_grant updated on every grant entry. A lone requester is always granted.
- Undefined: fixed D-cache priority; last_grant register absent.

## Test plan
- Reset: hold RESET=0 with both requests high -> mem_read=mem_write=0, both busywaits 0. Release -> GRANT_D next edge.
- Lone I-cache read, addr 0x0000010, memory N=5, data 0xDEADBEEF_...: mem_read high with addr 0x0000010 from cycle 1. icache_mem_busywait low only in cycle 6, readdata matches. Then IDLE.
- Lone D-cache write, addr 0x00000A3, data 0x1111...: mem_write high with that addr/data until completion. mem_read never high.
- Simultaneous I read 0x20 and D read 0x40, priority build: D served first. I busywait stays 1 throughout, one IDLE cycle, then I served.
- Same stimulus, MEM_ARB_ROUND_ROBIN_EN, both requests re-asserted continuously: grants alternate D, I, D, I starting with D (last_grant=I after reset).
- RESET asserted mid-GRANT_D: mem_write drops asynchronously, state IDLE. After release, pending I read is granted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Purpose : serialise I-cache refills and D-cache refills/write-backs onto one memory block port.
// Latency : request sampled in IDLE -> memory command next cycle; requester released in the memory's completion cycle.
// Backpr. : a requester sees busywait=1 until its own transaction completes; memory busywait stalls the granted side.
//
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to alternate grants when both caches request together
// (default build: fixed D-cache priority, no last_grant register).
//
// Ports:
//   CLK, RESET (async, active-low)
//   icache_mem_read/address -> icache_mem_readdata/busywait   : I-cache side
//   dcache_mem_read/write/address/writedata -> dcache_mem_readdata/busywait : D-cache side
//   mem_read/write/address/writedata <- mem_readdata/busywait : shared memory port
module mem_arbiter #(
    parameter int ADDR_W  = 28,
    parameter int BLOCK_W = 128
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               icache_mem_read,
    input  logic [ADDR_W-1:0]  icache_mem_address,
    output logic [BLOCK_W-1:0] icache_mem_readdata,
    output logic               icache_mem_busywait,
    input  logic               dcache_mem_read,
    input  logic               dcache_mem_write,
    input  logic [ADDR_W-1:0]  dcache_mem_address,
    input  logic [BLOCK_W-1:0] dcache_mem_writedata,
    output logic [BLOCK_W-1:0] dcache_mem_readdata,
    output logic               dcache_mem_busywait,
    output logic               mem_read,
    output logic               mem_write,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [BLOCK_W-1:0] mem_writedata,
    input  logic [BLOCK_W-1:0] mem_readdata,
    input  logic               mem_busywait
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   issued, issued_nxt;
    logic   d_req;
    logic   i_req;
    logic   completion;
    logic   pick_d;
    logic   pick_i;

    assign d_req = dcache_mem_read | dcache_mem_write;
    assign i_req = icache_mem_read;

    // issued hides the first grant cycle, before the memory has had a chance
    // to raise its busywait in response to the new command.
    assign completion = (state != IDLE) && issued && !mem_busywait;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // last_grant: 0 = I-cache, 1 = D-cache.
    logic last_grant, last_grant_nxt;

    // On contention favour whoever was not granted last; a lone requester always wins.
    assign pick_d = d_req && (!i_req || !last_grant);
    assign pick_i = i_req && (!d_req || last_grant);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            last_grant <= 1'b0;
        end else begin
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        last_grant_nxt = last_grant;
        if (state == IDLE) begin
            if (pick_d) begin
                last_grant_nxt = 1'b1;
            end else if (pick_i) begin
                last_grant_nxt = 1'b0;
            end
        end
    end
`else
    assign pick_d = d_req;
    assign pick_i = i_req && !d_req;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state  <= IDLE;
            issued <= 1'b0;
        end else begin
            state  <= state_nxt;
            issued <= issued_nxt;
        end
    end

    // A requester dropping its request mid-grant is not legal, but the FSM
    // still leaves on completion because completion ignores the request lines.
    always_comb begin
        state_nxt  = state;
        issued_nxt = issued;
        case (state)
            IDLE: begin
                issued_nxt = 1'b0;
                if (pick_d) begin
                    state_nxt = GRANT_D;
                end else if (pick_i) begin
                    state_nxt = GRANT_I;
                end
            end
            GRANT_I, GRANT_D: begin
                issued_nxt = 1'b1;
                if (completion) begin
                    state_nxt  = IDLE;
                    issued_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt  = IDLE;
                issued_nxt = 1'b0;
            end
        endcase
    end

    // Memory command follows the granted side's live inputs; the state register
    // resets asynchronously, so the command drops the moment RESET falls.
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        case (state)
            GRANT_I: begin
                mem_read    = icache_mem_read;
                mem_address = icache_mem_address;
            end
            GRANT_D: begin
                mem_read      = dcache_mem_read;
                mem_write     = dcache_mem_write;
                mem_address   = dcache_mem_address;
                mem_writedata = dcache_mem_writedata;
            end
            default: begin
            end
        endcase
    end

    // Stall each requester until its own grant completes; both forced low in reset.
    assign icache_mem_busywait = RESET && i_req && !((state == GRANT_I) && completion);
    assign dcache_mem_busywait = RESET && d_req && !((state == GRANT_D) && completion);

    // Read data is shared; each side only trusts it while its busywait is low.
    assign icache_mem_readdata = mem_readdata;
    assign dcache_mem_readdata = mem_readdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int BW = 128;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          icache_mem_read;
    logic [AW-1:0] icache_mem_address;
    logic [BW-1:0] icache_mem_readdata;
    logic          icache_mem_busywait;
    logic          dcache_mem_read;
    logic          dcache_mem_write;
    logic [AW-1:0] dcache_mem_address;
    logic [BW-1:0] dcache_mem_writedata;
    logic [BW-1:0] dcache_mem_readdata;
    logic          dcache_mem_busywait;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [BW-1:0] mem_writedata;
    logic [BW-1:0] mem_readdata;
    logic          mem_busywait;

    int checks = 0;
    int errors = 0;
    int mem_n  = 1;
    int mem_cnt;
    bit last_d = 1'b0;   // reference model: last grant went to the D-cache

    always #5 CLK = ~CLK;

    mem_arbiter #(.ADDR_W(AW), .BLOCK_W(BW)) dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .icache_mem_read      (icache_mem_read),
        .icache_mem_address   (icache_mem_address),
        .icache_mem_readdata  (icache_mem_readdata),
        .icache_mem_busywait  (icache_mem_busywait),
        .dcache_mem_read      (dcache_mem_read),
        .dcache_mem_write     (dcache_mem_write),
        .dcache_mem_address   (dcache_mem_address),
        .dcache_mem_writedata (dcache_mem_writedata),
        .dcache_mem_readdata  (dcache_mem_readdata),
        .dcache_mem_busywait  (dcache_mem_busywait),
        .mem_read             (mem_read),
        .mem_write            (mem_write),
        .mem_address          (mem_address),
        .mem_writedata        (mem_writedata),
        .mem_readdata         (mem_readdata),
        .mem_busywait         (mem_busywait)
    );

    function automatic logic [BW-1:0] pattern(input logic [AW-1:0] a);
        return {32'hDEADBEEF, 4'h0, a, 64'h0123_4567_89AB_CDEF};
    endfunction

    // Memory: busywait stays low in the command's first cycle, is high for the
    // next mem_n-1 cycles, and the command completes mem_n cycles after it appears.
    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mem_cnt <= 0;
        end else if (mem_read || mem_write) begin
            mem_cnt <= mem_cnt + 1;
        end else begin
            mem_cnt <= 0;
        end
    end
    assign mem_busywait = (mem_read || mem_write) && (mem_cnt >= 1) && (mem_cnt < mem_n);
    assign mem_readdata = pattern(mem_address);

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge with the arbiter idle. Cycle 0 is the idle
    // cycle in which requests are first seen. Each requester holds its request
    // through its completion cycle. First transaction completes at 1+n; if both
    // requested, one idle cycle follows and the second completes at 3+2n.
    task automatic run_round(input bit doi, input bit dod, input bit dwr, input int n,
                             input logic [AW-1:0] ia, input logic [AW-1:0] da,
                             input logic [BW-1:0] wd);
        bit d_first;
        bit gi;
        bit gd;
        int ci;
        int cd;
        int last;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        d_first = dod && (!doi || !last_d);
`else
        d_first = dod;
`endif
        ci   = !doi ? -1 : ((dod && d_first) ? 3 + 2 * n : 1 + n);
        cd   = !dod ? -1 : ((doi && !d_first) ? 3 + 2 * n : 1 + n);
        last = (doi && dod) ? 3 + 2 * n : 1 + n;
        mem_n = n;
        for (int t = 0; t <= last; t++) begin
            icache_mem_read      = doi && (t <= ci);
            icache_mem_address   = ia;
            dcache_mem_read      = dod && !dwr && (t <= cd);
            dcache_mem_write     = dod && dwr && (t <= cd);
            dcache_mem_address   = da;
            dcache_mem_writedata = wd;
            @(negedge CLK);
            gi = doi && (t >= ci - n) && (t <= ci);
            gd = dod && (t >= cd - n) && (t <= cd);
            chk("icache_busywait", icache_mem_busywait, doi && (t < ci));
            chk("dcache_busywait", dcache_mem_busywait, dod && (t < cd));
            chk("mem_read", mem_read, gi || (gd && !dwr));
            chk("mem_write", mem_write, gd && dwr);
            if (gi) chk("mem_address_i", mem_address, ia);
            if (gd) chk("mem_address_d", mem_address, da);
            if (gd && dwr) chk("mem_writedata", mem_writedata, wd);
            if (doi && t == ci) chk("icache_readdata", icache_mem_readdata, pattern(ia));
            if (dod && !dwr && t == cd) chk("dcache_readdata", dcache_mem_readdata, pattern(da));
            @(posedge CLK);
            #1;
        end
        icache_mem_read  = 1'b0;
        dcache_mem_read  = 1'b0;
        dcache_mem_write = 1'b0;
        last_d = (doi && dod) ? !d_first : dod;
    endtask

    initial begin
        // Reset held with both caches requesting.
        RESET                = 1'b0;
        icache_mem_read      = 1'b1;
        icache_mem_address   = 28'h20;
        dcache_mem_read      = 1'b1;
        dcache_mem_write     = 1'b0;
        dcache_mem_address   = 28'h40;
        dcache_mem_writedata = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_mem_address", mem_address, '0);
        chk("rst_mem_writedata", mem_writedata, '0);
        chk("rst_icache_busywait", icache_mem_busywait, 1'b0);
        chk("rst_dcache_busywait", dcache_mem_busywait, 1'b0);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        last_d = 1'b0;
        run_round(1'b1, 1'b1, 1'b0, 3, 28'h20, 28'h40, '0);

        // Directed transactions.
        run_round(1'b1, 1'b0, 1'b0, 5, 28'h0000010, 28'h0, '0);
        run_round(1'b0, 1'b1, 1'b1, 4, 28'h0, 28'h00000A3, {16{8'h11}});
        run_round(1'b1, 1'b1, 1'b0, 2, 28'h20, 28'h40, '0);
        run_round(1'b1, 1'b1, 1'b1, 1, 28'h33, 28'h44, {4{32'hCAFEF00D}});

        // Reset in the middle of a D-cache write, with an I-cache read pending.
        mem_n                = 8;
        dcache_mem_write     = 1'b1;
        dcache_mem_read      = 1'b0;
        dcache_mem_address   = 28'h0ABCDEF;
        dcache_mem_writedata = {8{16'h5A5A}};
        @(posedge CLK);
        #1;
        icache_mem_read    = 1'b1;
        icache_mem_address = 28'h0000055;
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
        chk("midrst_pre_write", mem_write, 1'b1);
        chk("midrst_pre_addr", mem_address, 28'h0ABCDEF);
        RESET = 1'b0;
        #1;
        chk("midrst_write_drop", mem_write, 1'b0);
        chk("midrst_read_low", mem_read, 1'b0);
        chk("midrst_icache_bw", icache_mem_busywait, 1'b0);
        chk("midrst_dcache_bw", dcache_mem_busywait, 1'b0);
        dcache_mem_write = 1'b0;
        @(posedge CLK);
        #1;
        RESET  = 1'b1;
        last_d = 1'b0;
        run_round(1'b1, 1'b0, 1'b0, 3, 28'h0000055, 28'h0, '0);

        // Randomised rounds.
        for (int r = 0; r < 40; r++) begin
            logic [1:0]    sel;
            logic [AW-1:0] ra;
            logic [AW-1:0] rb;
            logic [BW-1:0] rd;
            sel = 2'($urandom_range(1, 3));
            ra  = AW'($urandom);
            rb  = AW'($urandom);
            rd  = {$urandom, $urandom, $urandom, $urandom};
            run_round(sel[0], sel[1], 1'($urandom_range(0, 1)), int'($urandom_range(1, 6)), ra, rb, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
